score_keeper: RTL and testbench

- Producer end of the score interface. Game logic drives it; the score renderer reads it.
- Counts score while the player holds the move button, paced by frame ticks, and saturates at a maximum.
- Tracks game state (idle, playing, over) and latches a high score.
- Converts the binary score to three BCD digits with a sequential double-dabble, so the renderer needs no combinational divide/modulo.

---
 rtl/score_pkg.sv | 24 ++
 rtl/score_keeper_bin2bcd.sv | 53 +++++
 rtl/score_keeper.sv | 107 ++++++++++
 tb/tb_score_keeper.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types, widths and the double-dabble step for the score keeper.
package score_pkg;

    localparam int unsigned SCORE_W     = 8;
    localparam int unsigned BCD_DIGITS  = 3;
    localparam int unsigned BCD_W       = 4;
    localparam int unsigned BCD_TOTAL_W = BCD_DIGITS * BCD_W;
    localparam int unsigned SR_W        = BCD_TOTAL_W + SCORE_W;

    typedef enum logic [1:0] {IDLE, PLAYING, OVER} game_state_t;
    typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_DONE} conv_state_t;

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
    function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] v);
        logic [SR_W-1:0] r;
        r = v;
        for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
            if (r[SCORE_W + d*BCD_W +: BCD_W] >= 4'd5)
                r[SCORE_W + d*BCD_W +: BCD_W] = r[SCORE_W + d*BCD_W +: BCD_W] + 4'd3;
        end
        return {r[SR_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/score_keeper_bin2bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter; outputs hold until a conversion completes.
module bin2bcd_seq
    import score_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [SCORE_W-1:0]     bin,
    output logic                   busy,
    output logic                   done,
    output logic [BCD_TOTAL_W-1:0] bcd
);

    conv_state_t     state;
    logic [2:0]      iter;
    logic [SR_W-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CV_IDLE;
            iter  <= '0;
            sr    <= '0;
            bcd   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                CV_IDLE: begin
                    if (start) begin
                        sr    <= {{BCD_TOTAL_W{1'b0}}, bin};
                        iter  <= '0;
                        state <= CV_SHIFT;
                    end
                end
                CV_SHIFT: begin
                    sr   <= dd_step(sr);
                    iter <= iter + 3'd1;
                    if (iter == 3'd7)
                        state <= CV_DONE;
                end
                CV_DONE: begin
                    bcd   <= sr[SR_W-1:SCORE_W];
                    done  <= 1'b1;
                    state <= CV_IDLE;
                end
                default: state <= CV_IDLE;
            endcase
        end
    end

    assign busy = (state != CV_IDLE);

endmodule

// File: rtl/score_keeper.sv
// Score keeper: game FSM, move-paced scoring with saturation, BCD conversion.
// Optional high-score latch enabled by defining SCORE_HIGH_SCORE_EN.
module score_keeper #(
    parameter int unsigned MOVE_PERIOD = 4,
    parameter int unsigned SCORE_MAX   = 255,
    parameter int unsigned SCORE_W     = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_frame_tick,
    input  logic               i_move,
    input  logic               i_game_start,
    input  logic               i_game_over,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] o_high_score,
    output logic [3:0]         o_bcd_hundreds,
    output logic [3:0]         o_bcd_tens,
    output logic [3:0]         o_bcd_ones,
    output logic               o_bcd_valid,
    output logic               o_playing
);
    import score_pkg::*;

    localparam logic [SCORE_W-1:0] MP_LAST = SCORE_W'(MOVE_PERIOD - 1);
    localparam logic [SCORE_W-1:0] SMAX    = SCORE_W'(SCORE_MAX);

    game_state_t           state;
    logic [SCORE_W-1:0]    frame_cnt;
    logic [SCORE_W-1:0]    last_conv;
    logic                  conv_busy;
    logic                  conv_start;
    logic [BCD_TOTAL_W-1:0] bcd;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            o_score   <= '0;
            frame_cnt <= '0;
            o_playing <= 1'b0;
        end else begin
            case (state)
                IDLE, OVER: begin
                    if (i_game_start) begin
                        state     <= PLAYING;
                        o_score   <= '0;
                        frame_cnt <= '0;
                        o_playing <= 1'b1;
                    end
                end
                PLAYING: begin
                    if (i_game_over) begin
                        state     <= OVER;
                        o_playing <= 1'b0;
                    end else if (!i_move) begin
                        frame_cnt <= '0;
                    end else if (i_frame_tick) begin
                        if (frame_cnt == MP_LAST) begin
                            frame_cnt <= '0;
                            if (o_score < SMAX)
                                o_score <= o_score + 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCORE_HIGH_SCORE_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_high_score <= '0;
        else if (state == PLAYING && i_game_over && o_score > o_high_score)
            o_high_score <= o_score;
    end
`else
    assign o_high_score = '0;
`endif

    // The converter only accepts start while idle, so recording the value at
    // start is equivalent to recording it when the conversion completes.
    assign conv_start = !conv_busy && (o_score != last_conv);

    always_ff @(posedge i_clk) begin
        if (i_rst)
            last_conv <= '0;
        else if (conv_start)
            last_conv <= o_score;
    end

    bin2bcd_seq u_bcd (
        .clk   (i_clk),
        .rst   (i_rst),
        .start (conv_start),
        .bin   (o_score),
        .busy  (conv_busy),
        .done  (o_bcd_valid),
        .bcd   (bcd)
    );

    assign o_bcd_hundreds = bcd[11:8];
    assign o_bcd_tens     = bcd[7:4];
    assign o_bcd_ones     = bcd[3:0];

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: MOVE_PERIOD=4 and MOVE_PERIOD=1 instances share stimulus.
module tb_score_keeper;

`ifdef SCORE_HIGH_SCORE_EN
    localparam int HS_EXP = 123;
`else
    localparam int HS_EXP = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1, tick = 1'b0, move = 1'b0, gstart = 1'b0, gover = 1'b0;

    logic [7:0] a_score, a_high, b_score, b_high;
    logic [3:0] a_h, a_t, a_o, b_h, b_t, b_o;
    logic       a_valid, a_play, b_valid, b_play;

    int checks = 0, errors = 0;
    int va = 0, vb = 0;

    always #5 clk = ~clk;

    score_keeper #(.MOVE_PERIOD(4), .SCORE_MAX(255), .SCORE_W(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_frame_tick(tick), .i_move(move),
        .i_game_start(gstart), .i_game_over(gover),
        .o_score(a_score), .o_high_score(a_high),
        .o_bcd_hundreds(a_h), .o_bcd_tens(a_t), .o_bcd_ones(a_o),
        .o_bcd_valid(a_valid), .o_playing(a_play)
    );

    score_keeper #(.MOVE_PERIOD(1), .SCORE_MAX(255), .SCORE_W(8)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_frame_tick(tick), .i_move(move),
        .i_game_start(gstart), .i_game_over(gover),
        .o_score(b_score), .o_high_score(b_high),
        .o_bcd_hundreds(b_h), .o_bcd_tens(b_t), .o_bcd_ones(b_o),
        .o_bcd_valid(b_valid), .o_playing(b_play)
    );

    always @(posedge clk) begin
        #2;
        if (a_valid) va++;
        if (b_valid) vb++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; tick = 1'b0; move = 1'b0; gstart = 1'b0; gover = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); gstart = 1'b1;
        @(negedge clk); gstart = 1'b0;
    endtask

    task automatic pulse_over();
        @(negedge clk); gover = 1'b1;
        @(negedge clk); gover = 1'b0;
    endtask

    // One frame tick, then n cycles; lat is the cycle index at which o_bcd_valid appeared.
    task automatic do_tick(input int n, output int lat_a, output int lat_b);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        lat_a = -1; lat_b = -1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (a_valid && lat_a < 0) lat_a = k;
            if (b_valid && lat_b < 0) lat_b = k;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (a_score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", a_score); end
        checks++; if (a_high !== 8'd0) begin errors++; $display("FAIL reset_high: got %0d expected 0", a_high); end
        checks++; if ({a_h, a_t, a_o} !== 12'h000) begin errors++; $display("FAIL reset_bcd: got %h expected 000", {a_h, a_t, a_o}); end
        checks++; if ({a_valid, a_play, b_valid, b_play} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {a_valid, a_play, b_valid, b_play}); end
    endtask

    task automatic test_move_count();
        int la, lb;
        pulse_start();
        checks++; if (a_play !== 1'b1) begin errors++; $display("FAIL start_playing: got %b expected 1", a_play); end
        move = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            do_tick(12, la, lb);
            if (i % 4 == 0) begin
                checks++; if (a_score !== 8'(i / 4)) begin errors++; $display("FAIL count_score: got %0d expected %0d", a_score, i / 4); end
                checks++; if (la != 10) begin errors++; $display("FAIL bcd_latency: got %0d expected 10", la); end
            end
        end
        checks++; if ({a_h, a_t, a_o} !== 12'h002) begin errors++; $display("FAIL count_bcd: got %h expected 002", {a_h, a_t, a_o}); end
        move = 1'b0;
    endtask

    task automatic test_move_release();
        int la, lb;
        pulse_over();
        pulse_start();
        checks++; if (a_score !== 8'd0) begin errors++; $display("FAIL restart_score: got %0d expected 0", a_score); end
        repeat (12) @(negedge clk);
        move = 1'b1;
        for (int i = 0; i < 3; i++) do_tick(12, la, lb);
        move = 1'b0;
        @(negedge clk);
        move = 1'b1;
        for (int i = 0; i < 3; i++) do_tick(12, la, lb);
        checks++; if (a_score !== 8'd0) begin errors++; $display("FAIL release_clears: got %0d expected 0", a_score); end
        do_tick(12, la, lb);
        checks++; if (a_score !== 8'd1) begin errors++; $display("FAIL release_fourth: got %0d expected 1", a_score); end
        checks++; if (la != 10) begin errors++; $display("FAIL release_latency: got %0d expected 10", la); end
        move = 1'b0;
    endtask

    task automatic test_saturate();
        int la, lb, base;
        do_reset();
        pulse_start();
        base = vb;
        move = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            do_tick(12, la, lb);
            if (i == 255) begin
                checks++; if (b_score !== 8'd255) begin errors++; $display("FAIL sat_reach: got %0d expected 255", b_score); end
            end
        end
        move = 1'b0;
        checks++; if (b_score !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", b_score); end
        checks++; if ({b_h, b_t, b_o} !== 12'h255) begin errors++; $display("FAIL sat_bcd: got %h expected 255", {b_h, b_t, b_o}); end
        checks++; if (vb - base != 255) begin errors++; $display("FAIL sat_pulses: got %0d expected 255", vb - base); end
    endtask

    task automatic test_high_score();
        int la, lb;
        do_reset();
        checks++; if (b_high !== 8'd0) begin errors++; $display("FAIL hs_reset: got %0d expected 0", b_high); end
        pulse_start();
        move = 1'b1;
        for (int i = 0; i < 123; i++) do_tick(12, la, lb);
        checks++; if (b_score !== 8'd123) begin errors++; $display("FAIL hs_score: got %0d expected 123", b_score); end
        move = 1'b0;
        pulse_over();
        checks++; if (b_play !== 1'b0) begin errors++; $display("FAIL hs_over_state: got %b expected 0", b_play); end
        checks++; if (b_high !== 8'(HS_EXP)) begin errors++; $display("FAIL hs_latch: got %0d expected %0d", b_high, HS_EXP); end
        move = 1'b1;
        for (int i = 0; i < 3; i++) do_tick(12, la, lb);
        checks++; if (b_score !== 8'd123) begin errors++; $display("FAIL hs_frozen: got %0d expected 123", b_score); end
        pulse_start();
        for (int i = 0; i < 50; i++) do_tick(12, la, lb);
        move = 1'b0;
        pulse_over();
        checks++; if (b_score !== 8'd50) begin errors++; $display("FAIL hs_second_score: got %0d expected 50", b_score); end
        checks++; if (b_high !== 8'(HS_EXP)) begin errors++; $display("FAIL hs_keep: got %0d expected %0d", b_high, HS_EXP); end
    endtask

    task automatic test_both_pulses();
        int la, lb, lat;
        pulse_start();
        move = 1'b1;
        for (int i = 0; i < 5; i++) do_tick(12, la, lb);
        move = 1'b0;
        @(negedge clk); gstart = 1'b1; gover = 1'b1;
        @(negedge clk); gstart = 1'b0; gover = 1'b0;
        checks++; if (b_play !== 1'b0) begin errors++; $display("FAIL both_state: got %b expected 0", b_play); end
        checks++; if (b_score !== 8'd5) begin errors++; $display("FAIL both_score: got %0d expected 5", b_score); end
        repeat (12) @(negedge clk);
        checks++; if ({b_h, b_t, b_o} !== 12'h005) begin errors++; $display("FAIL both_bcd: got %h expected 005", {b_h, b_t, b_o}); end
        pulse_start();
        checks++; if (b_score !== 8'd0) begin errors++; $display("FAIL over_restart: got %0d expected 0", b_score); end
        lat = -1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (b_valid && lat < 0) lat = k;
        end
        checks++; if (lat != 10) begin errors++; $display("FAIL restart_latency: got %0d expected 10", lat); end
        checks++; if ({b_h, b_t, b_o} !== 12'h000) begin errors++; $display("FAIL restart_bcd: got %h expected 000", {b_h, b_t, b_o}); end
    endtask

    task automatic test_reset_mid_conv();
        int la, lb, base;
        move = 1'b1;
        for (int i = 0; i < 98; i++) do_tick(12, la, lb);
        do_tick(4, la, lb);
        checks++; if (b_score !== 8'd99) begin errors++; $display("FAIL mid_score: got %0d expected 99", b_score); end
        base = vb;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; move = 1'b0;
        checks++; if ({b_score, b_high} !== 16'd0) begin errors++; $display("FAIL mid_reset_regs: got %h expected 0000", {b_score, b_high}); end
        checks++; if ({b_h, b_t, b_o, b_valid, b_play} !== 14'd0) begin errors++; $display("FAIL mid_reset_out: got %h expected 0", {b_h, b_t, b_o, b_valid, b_play}); end
        repeat (20) @(negedge clk);
        checks++; if (vb != base) begin errors++; $display("FAIL mid_no_pulse: got %0d pulses expected 0", vb - base); end
        checks++; if ({b_h, b_t, b_o} !== 12'h000) begin errors++; $display("FAIL mid_bcd_hold: got %h expected 000", {b_h, b_t, b_o}); end
    endtask

    initial begin
        test_reset();
        test_move_count();
        test_move_release();
        test_saturate();
        test_high_score();
        test_both_pulses();
        test_reset_mid_conv();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
